// File: rtl/dds_pkg.sv
// dds_pkg: shared FSM state type, tuning-word width and default reference clock for the DDS chain
package dds_pkg;
  typedef enum logic [1:0] {IDLE, CALC, ROUND, HOLD} state_t;
  localparam int TW_WIDTH = 32;
  localparam int unsigned REF_CLK_HZ = 125000000;
endpackage

// File: rtl/dds_tw_gen_if.sv
// dds_tw_gen_if: valid/ready tuning-word channel from the generator to the serial loader
interface dds_tw_gen_if import dds_pkg::*; ();
  logic [TW_WIDTH-1:0] tw_data;
  logic tw_valid;
  logic tw_ready;
  modport master (output tw_data, tw_valid, input tw_ready);
  modport slave (input tw_data, tw_valid, output tw_ready);
endinterface

// File: rtl/dds_debounce.sv
// dds_debounce: 2-flop synchronizer plus stability counter; sw_chg pulses in the cycle sw_db takes its new value
module dds_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic switch,
  output logic sw_db,
  output logic sw_chg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // Count consecutive synchronized samples that disagree with sw_db; accept on the last one
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      cnt <= '0;
      sw_db <= 1'b0;
      sw_chg <= 1'b0;
    end else begin
      sync <= {sync[0], switch};
      sw_chg <= 1'b0;
      if (sync[1] == sw_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        sw_db <= sync[1];
        sw_chg <= 1'b1;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/dds_tw_gen.sv
// dds_tw_gen: tuning word freq*2^32/REF_CLK via restoring divider; DDS_TW_ROUND_EN adds a round-to-nearest step
module dds_tw_gen import dds_pkg::*; #(
  parameter int unsigned REF_CLK = REF_CLK_HZ,
  parameter int unsigned FREQ_0 = 10000000,
  parameter int unsigned FREQ_1 = 20000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                switch,
  input  logic [TW_WIDTH-1:0] freq_in,
  input  logic                freq_wr,
  dds_tw_gen_if.master        tw,
  output logic                busy,
  output logic                freq_err
);
  localparam int RW = TW_WIDTH + 1;
`ifdef DDS_TW_ROUND_EN
  localparam state_t LAST = ROUND;
`else
  localparam state_t LAST = HOLD;
`endif
  logic sw_db, sw_chg, pend, wr_ok, new_req, ge;
  logic [TW_WIDTH-1:0] pend_freq, q;
  logic [RW-1:0] rem, rem2;
  logic [4:0] cnt;
  state_t state, state_nx;

  dds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .reset(reset), .switch(switch), .sw_db(sw_db), .sw_chg(sw_chg)
  );

  assign wr_ok = freq_wr && freq_in < TW_WIDTH'(REF_CLK / 2);
  assign new_req = wr_ok || (sw_chg && !freq_wr);
  assign rem2 = rem << 1;
  assign ge = rem2 >= RW'(REF_CLK);

  // Single pending slot: newest request wins, freq_wr beats a simultaneous switch change
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= 1'b1;
      pend_freq <= TW_WIDTH'(FREQ_0);
      freq_err <= 1'b0;
    end else begin
      freq_err <= freq_wr && !wr_ok;
      if (new_req) begin
        pend <= 1'b1;
        pend_freq <= wr_ok ? freq_in : (sw_db ? TW_WIDTH'(FREQ_1) : TW_WIDTH'(FREQ_0));
      end else if (state == IDLE) pend <= 1'b0;
    end

  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = pend ? CALC : IDLE;
      CALC:  state_nx = cnt == 5'd31 ? LAST : CALC;
      ROUND: state_nx = HOLD;
      HOLD:  state_nx = tw.tw_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring divider: one quotient bit per CALC cycle, optional saturating round-up after
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rem <= '0;
      q <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (pend) begin
          rem <= {1'b0, pend_freq};
          q <= '0;
          cnt <= '0;
        end
        CALC: begin
          rem <= ge ? rem2 - RW'(REF_CLK) : rem2;
          q <= {q[TW_WIDTH-2:0], ge};
          cnt <= cnt + 5'd1;
        end
        ROUND: if (ge && !(&q)) q <= q + TW_WIDTH'(1);
        default: ;
      endcase

  // Outputs decoded from the registered state
  always_comb begin
    tw.tw_valid = state == HOLD;
    tw.tw_data = state == HOLD ? q : '0;
    busy = state != IDLE;
  end
endmodule

// File: doc/dds_tw_gen.md
# dds_tw_gen

Tuning-word generator sitting directly upstream of the AD9850 serial loader. It debounces the frequency-select switch and accepts runtime frequency writes. For each request it computes the 32-bit tuning word freq·2^32/REF_CLK with a sequential restoring divider, then hands the word to the loader over a valid/ready handshake. It replaces the constant-division logic in the loader, so the loader only shifts out what it receives.

## Interface
Parameters:
- REF_CLK, 125000000, DDS reference clock in Hz; must be < 2^31.
- FREQ_0, 10000000, frequency in Hz selected when the debounced switch is 0.
- FREQ_1, 20000000, frequency in Hz selected when the debounced switch is 1.
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronized samples needed to accept a switch change; must be ≥ 2.

Ports:
- clk  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- switch  in  1  raw frequency-select switch; asynchronous to clk.
- freq_in  in  32  runtime frequency in Hz.
- freq_wr  in  1  single-cycle strobe that captures freq_in.
- tw_data  out  32  tuning word; stable while tw_valid is high.
- tw_valid  out  1  tuning word available.
- tw_ready  in  1  loader accepts the word.
- busy  out  1  high in CALC, ROUND or HOLD.
- freq_err  out  1  one-cycle pulse when freq_wr is rejected.

## Operation
- Switch path: 2-flop synchronizer, then a stability counter. The debounced value sw_db changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from sw_db. A change of sw_db raises a request with FREQ_1 or FREQ_0.
- freq_wr path: freq_in ≥ REF_CLK/2 (Nyquist) → request dropped, freq_err pulses the next cycle. Otherwise a request is raised with freq_in.
- Request arbitration:
  - If freq_wr and an sw_db change occur in the same cycle, freq_wr wins and the switch request is discarded.
  - A single pending slot holds the newest request; a later request overwrites it.
  - The pending slot is serviced when the FSM is in IDLE.
- FSM states:
  - IDLE: if a request is pending → CALC; load rem = {1'b0, freq}, q = 0, cnt = 0; clear pending.
  - CALC: 32 cycles. Each cycle: rem2 = rem<<1; if rem2 ≥ REF_CLK then rem = rem2 − REF_CLK and shift in a 1, else rem = rem2 and shift in a 0. q is 32 bits, rem is 33 bits, compares are unsigned. At cnt == 31 → ROUND (macro defined) or HOLD.
  - ROUND: see Configuration; → HOLD.
  - HOLD: tw_valid = 1 and tw_data = q. When tw_valid && tw_ready → IDLE.
- Result is floor(freq·2^32/REF_CLK); freq < REF_CLK/2 guarantees it fits in 32 bits.
- A request arriving during CALC/ROUND/HOLD never aborts the current word; it is computed after the handshake completes.
- Reset forces sw_db = 0 and the pending slot = FREQ_0. The first word after reset is therefore FREQ_0's, followed by FREQ_1's once the debounce settles, if the switch reads 1.

## Timing
- Reset values:
  - tw_data = 0, tw_valid = 0, busy = 0, freq_err = 0.
  - FSM = IDLE, pending = FREQ_0, sw_db = 0, debounce counter = 0.
- Asserting reset in any state returns the block to these values immediately; a word being held is lost.
- Latency: the IDLE cycle that takes the request is cycle 0. tw_valid rises at cycle 33 without ROUND_EN and at cycle 34 with it.
- tw_valid stays high and tw_data stays unchanged until the cycle tw_ready is sampled high. The earliest next tw_valid is 34 (35) cycles later.
- tw_ready while tw_valid = 0 is ignored.
- busy is registered: high from cycle 1 through the handshake cycle.
- Switch latency: raw edge to request = 2 synchronizer cycles + DEBOUNCE_CYCLES.

## Configuration
- DDS_TW_ROUND_EN defined:
  - ROUND state included.
  - If 2·rem ≥ REF_CLK, then q = q + 1, saturating at 0xFFFFFFFF.
  - Result is round-to-nearest; latency 34.
- Undefined: no ROUND state, truncated result, latency 33.

## Structure
- Shared package dds_pkg holds:
  - the state_t enum (IDLE, CALC, ROUND, HOLD);
  - TW_WIDTH = 32;
  - the default REF_CLK constant, also used by the loader.
- Sub-module dds_debounce: synchronizer plus stability counter, parameter DEBOUNCE_CYCLES, output sw_db.

## Test plan
- Reset release, switch held 0, tw_ready = 1 → exactly one word 0x147AE147 (0x147AE148 with DDS_TW_ROUND_EN) at cycle 33/34; no further words.
- Switch 0→1 held stable, DEBOUNCE_CYCLES = 8 → word 0x28F5C28F (both builds). Glitches shorter than 8 cycles produce no word.
- freq_wr with freq_in = 62500000 → freq_err pulse, no word. freq_in = 62499999 → word produced, no freq_err.
- tw_ready held low for 100 cycles in HOLD → tw_valid and tw_data stable throughout. Two freq_wr (1 MHz, then 5 MHz) during the hold → after the handshake only the 5 MHz word (0x0A3D70A3 truncated) follows.
- freq_wr and a switch change in the same cycle → only the freq_in word is produced.
- Reset asserted in mid-CALC (cnt = 15) → all outputs reset immediately. After release, the FREQ_0 word is recomputed with full latency.
